// File: rtl/memory_arbiter_pkg.sv
// Shared types for the instruction/data memory bus arbiter.
package memory_arbiter_pkg;

   typedef enum logic [1:0] {
      Idle     = 2'd0,
      InstXfer = 2'd1,
      DataXfer = 2'd2
   } arbiter_state_t;

   typedef enum logic {
      GrantInst = 1'b0,
      GrantData = 1'b1
   } grant_t;

endpackage

// File: rtl/memory_bus_arbiter.sv
// Round-robin merge of the instruction and data ports onto one Wishbone-classic master bus.
// Optional MEM_ARB_TIMEOUT_EN aborts a transfer that sees no bus_ack within TimeoutCycles.
module memory_bus_arbiter
   import memory_arbiter_pkg::*;
#(
   parameter int unsigned Width         = 32,
   parameter int unsigned TimeoutCycles = 255
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               inst_mem_en,
   input  logic [Width-1:0]   inst_mem_addr,
   output logic               inst_mem_ack,
   output logic [Width-1:0]   inst_mem_dat,
   output logic               inst_mem_err,
   input  logic               data_mem_en,
   input  logic               data_mem_we,
   input  logic [Width-1:0]   data_mem_addr,
   input  logic [Width/8-1:0] data_mem_sel,
   input  logic [Width-1:0]   data_mem_wdat,
   output logic               data_mem_ack,
   output logic [Width-1:0]   data_mem_dat,
   output logic               data_mem_err,
   output logic               bus_cyc,
   output logic               bus_stb,
   output logic               bus_we,
   output logic [Width-1:0]   bus_addr,
   output logic [Width/8-1:0] bus_sel,
   output logic [Width-1:0]   bus_wdat,
   input  logic               bus_ack,
   input  logic [Width-1:0]   bus_rdat
);

   arbiter_state_t state;
   grant_t         last_grant;
   logic           grant_inst;
   logic           grant_data;
   logic           timeout_hit;

   // On contention the port that did not win last time gets the bus.
   always_comb begin
      grant_inst = inst_mem_en && (!data_mem_en || last_grant == GrantData);
      grant_data = data_mem_en && !grant_inst;
   end

   // A dropped enable still lets the bus cycle finish, but the ack is swallowed.
   always_comb begin
      inst_mem_ack = (state == InstXfer) && bus_ack && inst_mem_en;
      data_mem_ack = (state == DataXfer) && bus_ack && data_mem_en;
      inst_mem_dat = inst_mem_ack ? bus_rdat : '0;
      data_mem_dat = data_mem_ack ? bus_rdat : '0;
   end

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
   logic [CntW-1:0] tmo_cnt;

   // Counter holds the number of completed ack-less Xfer cycles, so the limit is hit one early.
   always_ff @(posedge clock) begin
      if (!reset || state == Idle) begin
         tmo_cnt <= '0;
      end else if (!bus_ack) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   always_comb begin
      timeout_hit  = (state != Idle) && !bus_ack && (tmo_cnt == CntW'(TimeoutCycles - 1));
      inst_mem_err = timeout_hit && (state == InstXfer);
      data_mem_err = timeout_hit && (state == DataXfer);
   end
`else
   always_comb begin
      timeout_hit  = 1'b0;
      inst_mem_err = 1'b0;
      data_mem_err = 1'b0;
   end
`endif

   assign bus_stb = bus_cyc;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= Idle;
         last_grant <= GrantInst;
         bus_cyc    <= 1'b0;
         bus_we     <= 1'b0;
         bus_addr   <= '0;
         bus_sel    <= '0;
         bus_wdat   <= '0;
      end else begin
         unique case (state)
            Idle: begin
               if (grant_inst) begin
                  state      <= InstXfer;
                  last_grant <= GrantInst;
                  bus_cyc    <= 1'b1;
                  bus_we     <= 1'b0;
                  bus_addr   <= inst_mem_addr;
                  bus_sel    <= '1;
                  bus_wdat   <= '0;
               end else if (grant_data) begin
                  state      <= DataXfer;
                  last_grant <= GrantData;
                  bus_cyc    <= 1'b1;
                  bus_we     <= data_mem_we;
                  bus_addr   <= data_mem_addr;
                  bus_sel    <= data_mem_sel;
                  bus_wdat   <= data_mem_wdat;
               end
            end
            InstXfer, DataXfer: begin
               if (bus_ack || timeout_hit) begin
                  state   <= Idle;
                  bus_cyc <= 1'b0;
               end
            end
            default: begin
               state   <= Idle;
               bus_cyc <= 1'b0;
            end
         endcase
      end
   end

endmodule
